// File: rtl/branch_predict_controller.sv
// Branch prediction controller: 2-bit counter direction table, BTB write scheduling with
// IF-side forwarding of the uncommitted write, EX-stage mispredict detection and statistics.
module branch_predict_controller #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned IDX_BITS  = 8,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // IF-stage prediction
  input  logic [WORD_SIZE-1:0] IF_pc,
  output logic [WORD_SIZE-1:0] btb_read_addr,
  input  logic [WORD_SIZE-1:0] btb_read_data,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_next_pc,
  // EX-stage resolution
  input  logic                 EX_valid,
  input  logic                 EX_is_branch,
  input  logic                 EX_is_cond,
  input  logic [WORD_SIZE-1:0] EX_pc,
  input  logic                 EX_taken,
  input  logic [WORD_SIZE-1:0] EX_target,
  input  logic                 EX_pred_taken,
  input  logic [WORD_SIZE-1:0] EX_pred_target,
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] redirect_pc,
  // BTB write port
  output logic                 BtbWrite,
  output logic [WORD_SIZE-1:0] btb_write_addr,
  output logic [WORD_SIZE-1:0] btb_write_data,
  // Statistics
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  typedef enum logic [2:0] {
    UPD_NONE,
    UPD_INC,
    UPD_DEC,
    UPD_SET_TAKEN,
    UPD_CLEAR
  } ctr_upd_e;

  logic [1:0]          ctr [ENTRIES];
  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [1:0]          ex_ctr;
  logic [1:0]          ctr_next;
  ctr_upd_e            upd_kind;
  logic                ex_take;
  logic                fwd_hit;
  logic [WORD_SIZE-1:0] pred_target;
  logic                dir_wrong;
  logic                tgt_wrong;

  assign if_idx        = IF_pc[IDX_BITS-1:0];
  assign ex_idx        = EX_pc[IDX_BITS-1:0];
  assign ex_ctr        = ctr[ex_idx];
  assign btb_read_addr = IF_pc;

  // The BTB only sees our write one cycle after BtbWrite rises, so a fetch of the
  // same PC in that cycle takes the target straight from the write registers.
  assign fwd_hit      = BtbWrite && (btb_write_addr == IF_pc);
  assign pred_target  = fwd_hit ? btb_write_data : btb_read_data;
  assign pred_taken   = ctr[if_idx][1];
  assign pred_next_pc = pred_taken ? pred_target : IF_pc + WORD_SIZE'(1);

  assign dir_wrong  = EX_taken != EX_pred_taken;
  assign tgt_wrong  = EX_taken && (EX_target != EX_pred_target);
  assign mispredict = EX_valid && (EX_is_branch ? (dir_wrong || tgt_wrong) : EX_pred_taken);
  assign redirect_pc = (EX_is_branch && EX_taken) ? EX_target : EX_pc + WORD_SIZE'(1);

  assign ex_take = EX_valid && EX_is_branch && EX_taken;

  // A non-branch that was predicted taken aliased onto a branch entry; clearing the
  // counter stops the same fetch PC from being steered away again.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    upd_kind = UPD_NONE;
    if (EX_valid) begin
      if (EX_is_branch) begin
        if (!EX_is_cond)    upd_kind = UPD_SET_TAKEN;
        else if (EX_taken)  upd_kind = UPD_INC;
        else                upd_kind = UPD_DEC;
      end else if (EX_pred_taken) begin
        upd_kind = UPD_CLEAR;
      end
    end
  end

  always_comb begin
    ctr_next = ex_ctr;
    unique case (upd_kind)
      UPD_INC:       ctr_next = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'b01;
      UPD_DEC:       ctr_next = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'b01;
      UPD_SET_TAKEN: ctr_next = 2'b11;
      UPD_CLEAR:     ctr_next = 2'b00;
      default:       ctr_next = ex_ctr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the counter table is reset explicitly because prediction depends on a
      // known CTR_INIT in every entry; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (upd_kind != UPD_NONE) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples
      // pre-edge values regardless of statement order.
      ctr[ex_idx] <= ctr_next;
    end
  end

  // Address/data hold their last values between writes; only the enable pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      BtbWrite       <= 1'b0;
      btb_write_addr <= '0;
      btb_write_data <= '0;
    end else begin
      BtbWrite <= ex_take;
      if (ex_take) begin
        btb_write_addr <= EX_pc;
        btb_write_data <= EX_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (EX_valid && EX_is_branch) stat_branches <= stat_branches + 16'd1;
      if (mispredict)               stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_controller.sv
// Self-checking bench for branch_predict_controller: a table of per-cycle vectors with a
// scoreboard for registered outputs, plus hand-written reset and counter-wrap sequences.
module tb_branch_predict_controller;

  logic        clk;
  logic        reset_n;
  logic [15:0] IF_pc, btb_read_addr, btb_read_data, pred_next_pc;
  logic        pred_taken;
  logic        EX_valid, EX_is_branch, EX_is_cond, EX_taken, EX_pred_taken;
  logic [15:0] EX_pc, EX_target, EX_pred_target;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic        BtbWrite;
  logic [15:0] btb_write_addr, btb_write_data, stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predict_controller dut (
    .clk(clk), .reset_n(reset_n),
    .IF_pc(IF_pc), .btb_read_addr(btb_read_addr), .btb_read_data(btb_read_data),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .EX_valid(EX_valid), .EX_is_branch(EX_is_branch), .EX_is_cond(EX_is_cond),
    .EX_pc(EX_pc), .EX_taken(EX_taken), .EX_target(EX_target),
    .EX_pred_taken(EX_pred_taken), .EX_pred_target(EX_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .BtbWrite(BtbWrite), .btb_write_addr(btb_write_addr), .btb_write_data(btb_write_data),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] if_pc, rd;
    logic        v, br, cond, tk, ptk;
    logic [15:0] ex_pc, tgt, ptgt;
    logic        e_pt;
    logic [15:0] e_npc;
    logic        e_mis;
    logic [15:0] e_rdr;
    logic        e_wr;
    logic [15:0] e_wa, e_wd;
  } vec_t;

  typedef struct {
    int          id;
    logic        wr;
    logic [15:0] wa, wd, br, mis;
  } sb_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];
  sb_t  sb_q [$];

  function automatic vec_t mk(
    input logic [15:0] if_pc, rd,
    input logic v, br, cond, input logic [15:0] ex_pc, input logic tk,
    input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt,
    input logic e_pt, input logic [15:0] e_npc, input logic e_mis, input logic [15:0] e_rdr,
    input logic e_wr, input logic [15:0] e_wa, e_wd);
    vec_t r;
    r.if_pc = if_pc; r.rd = rd; r.v = v; r.br = br; r.cond = cond; r.ex_pc = ex_pc;
    r.tk = tk; r.tgt = tgt; r.ptk = ptk; r.ptgt = ptgt;
    r.e_pt = e_pt; r.e_npc = e_npc; r.e_mis = e_mis; r.e_rdr = e_rdr;
    r.e_wr = e_wr; r.e_wa = e_wa; r.e_wd = e_wd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic v, br, cond, input logic [15:0] pc, input logic tk,
                          input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt);
    EX_valid = v; EX_is_branch = br; EX_is_cond = cond; EX_pc = pc;
    EX_taken = tk; EX_target = tgt; EX_pred_taken = ptk; EX_pred_target = ptgt;
  endtask

  initial begin
    logic [15:0] exp_br;
    logic [15:0] exp_mis;
    sb_t         e;

    //                  IF    rd     v  br cnd EXpc  tk tgt    ptk ptgt   ePT eNPC   eMIS eRDR   eWR eWA    eWD
    vecs[0]  = mk(16'h0010,16'h0011, 0,0,0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0011, 0,16'h0000, 0,16'h0000,16'h0000);
    vecs[1]  = mk(16'h0010,16'h0011, 1,1,1,16'h0020,1,16'h0030,0,16'h0021, 0,16'h0011, 1,16'h0030, 1,16'h0020,16'h0030);
    vecs[2]  = mk(16'h0020,16'h0021, 1,1,1,16'h0020,1,16'h0030,1,16'h0030, 1,16'h0030, 0,16'h0000, 1,16'h0020,16'h0030);
    vecs[3]  = mk(16'h0020,16'h0030, 1,1,1,16'h0020,1,16'h0030,1,16'h0030, 1,16'h0030, 0,16'h0000, 1,16'h0020,16'h0030);
    vecs[4]  = mk(16'h0020,16'h0030, 1,1,1,16'h0020,1,16'h0030,1,16'h0030, 1,16'h0030, 0,16'h0000, 1,16'h0020,16'h0030);
    vecs[5]  = mk(16'h0020,16'h0030, 1,1,1,16'h0020,0,16'h0030,1,16'h0030, 1,16'h0030, 1,16'h0021, 0,16'h0020,16'h0030);
    vecs[6]  = mk(16'h0020,16'h0030, 1,1,1,16'h0020,0,16'h0030,1,16'h0030, 1,16'h0030, 1,16'h0021, 0,16'h0020,16'h0030);
    vecs[7]  = mk(16'h0020,16'h0030, 1,1,1,16'h0020,0,16'h0030,0,16'h0021, 0,16'h0021, 0,16'h0000, 0,16'h0020,16'h0030);
    vecs[8]  = mk(16'h0020,16'h0030, 1,1,1,16'h0020,0,16'h0030,0,16'h0021, 0,16'h0021, 0,16'h0000, 0,16'h0020,16'h0030);
    vecs[9]  = mk(16'h0020,16'h0030, 0,0,0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0021, 0,16'h0000, 0,16'h0020,16'h0030);
    vecs[10] = mk(16'h0040,16'h0050, 1,1,0,16'h0040,1,16'h0060,1,16'h0050, 0,16'h0041, 1,16'h0060, 1,16'h0040,16'h0060);
    vecs[11] = mk(16'h0040,16'h0050, 1,1,1,16'h0045,1,16'h0070,0,16'h0046, 1,16'h0060, 1,16'h0070, 1,16'h0045,16'h0070);
    vecs[12] = mk(16'h0045,16'h0046, 1,0,0,16'h0045,0,16'h0000,1,16'h0070, 1,16'h0070, 1,16'h0046, 0,16'h0045,16'h0070);
    vecs[13] = mk(16'h0045,16'h0070, 1,0,0,16'h0046,0,16'h0000,0,16'h0000, 0,16'h0046, 0,16'h0000, 0,16'h0045,16'h0070);
    vecs[14] = mk(16'h0040,16'h0060, 0,1,1,16'h0040,1,16'h0099,0,16'h0050, 1,16'h0060, 0,16'h0000, 0,16'h0045,16'h0070);
    vecs[15] = mk(16'h0050,16'h0051, 1,1,1,16'h0120,1,16'h0200,0,16'h0121, 0,16'h0051, 1,16'h0200, 1,16'h0120,16'h0200);
    vecs[16] = mk(16'h0040,16'h0060, 0,0,0,16'h0000,0,16'h0000,0,16'h0000, 1,16'h0060, 0,16'h0000, 0,16'h0120,16'h0200);
    vecs[17] = mk(16'h0020,16'h0030, 0,0,0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0021, 0,16'h0000, 0,16'h0120,16'h0200);

    reset_n = 1'b0;
    IF_pc = 16'h0010; btb_read_data = 16'h0011;
    drive_ex(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset.BtbWrite", BtbWrite, 1'b0);
    check("reset.btb_write_addr", btb_write_addr, 16'h0000);
    check("reset.stat_branches", stat_branches, 16'h0000);
    check("reset.stat_mispredicts", stat_mispredicts, 16'h0000);

    exp_br = 16'h0000;
    exp_mis = 16'h0000;
    for (int i = 0; i < NVEC; i++) begin
      IF_pc = vecs[i].if_pc;
      btb_read_data = vecs[i].rd;
      drive_ex(vecs[i].v, vecs[i].br, vecs[i].cond, vecs[i].ex_pc, vecs[i].tk,
               vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      #2;
      check($sformatf("v%0d.btb_read_addr", i), btb_read_addr, vecs[i].if_pc);
      check($sformatf("v%0d.pred_taken", i), pred_taken, vecs[i].e_pt);
      check($sformatf("v%0d.pred_next_pc", i), pred_next_pc, vecs[i].e_npc);
      check($sformatf("v%0d.mispredict", i), mispredict, vecs[i].e_mis);
      if (vecs[i].e_mis)
        check($sformatf("v%0d.redirect_pc", i), redirect_pc, vecs[i].e_rdr);
      if (vecs[i].v && vecs[i].br) exp_br = exp_br + 16'd1;
      if (vecs[i].e_mis)           exp_mis = exp_mis + 16'd1;
      sb_q.push_back('{id: i, wr: vecs[i].e_wr, wa: vecs[i].e_wa, wd: vecs[i].e_wd,
                       br: exp_br, mis: exp_mis});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check($sformatf("v%0d.BtbWrite", e.id), BtbWrite, e.wr);
      check($sformatf("v%0d.btb_write_addr", e.id), btb_write_addr, e.wa);
      check($sformatf("v%0d.btb_write_data", e.id), btb_write_data, e.wd);
      check($sformatf("v%0d.stat_branches", e.id), stat_branches, e.br);
      check($sformatf("v%0d.stat_mispredicts", e.id), stat_mispredicts, e.mis);
    end

    // Reset mid-operation: a write pending from cycle N is dropped by reset at the N+1 edge.
    IF_pc = 16'h0010; btb_read_data = 16'h0011;
    drive_ex(1, 1, 1, 16'h0080, 1, 16'h0090, 0, 16'h0081);
    @(posedge clk);
    #1;
    check("rst_mid.BtbWrite_before", BtbWrite, 1'b1);
    check("rst_mid.addr_before", btb_write_addr, 16'h0080);
    reset_n = 1'b0;
    #2;
    check("rst_mid.mispredict_in_reset", mispredict, 1'b1);
    check("rst_mid.redirect_in_reset", redirect_pc, 16'h0090);
    @(posedge clk);
    #1;
    check("rst_mid.BtbWrite_after", BtbWrite, 1'b0);
    check("rst_mid.addr_after", btb_write_addr, 16'h0000);
    check("rst_mid.data_after", btb_write_data, 16'h0000);
    check("rst_mid.stat_branches", stat_branches, 16'h0000);
    check("rst_mid.stat_mispredicts", stat_mispredicts, 16'h0000);
    reset_n = 1'b1;
    drive_ex(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    IF_pc = 16'h0020; btb_read_data = 16'h0021;
    #2;
    check("rst_mid.ctr20_pred", pred_taken, 1'b0);
    check("rst_mid.ctr20_npc", pred_next_pc, 16'h0021);
    IF_pc = 16'h0040; btb_read_data = 16'h0041;
    #1;
    check("rst_mid.ctr40_pred", pred_taken, 1'b0);
    check("rst_mid.ctr40_npc", pred_next_pc, 16'h0041);

    // Both statistics counters wrap from 0xFFFF to 0x0000.
    drive_ex(1, 1, 1, 16'h0300, 1, 16'h0310, 0, 16'h0301);
    repeat (65535) @(posedge clk);
    #1;
    check("wrap.branches_ffff", stat_branches, 16'hFFFF);
    check("wrap.mispredicts_ffff", stat_mispredicts, 16'hFFFF);
    @(posedge clk);
    #1;
    check("wrap.branches_zero", stat_branches, 16'h0000);
    check("wrap.mispredicts_zero", stat_mispredicts, 16'h0000);
    drive_ex(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
